// File: rtl/pipe_seg_adder.sv
// rtl/pipe_seg_adder.sv - pipelined segmented ripple-carry adder/subtractor, one SEG-bit slice per stage
// Optional signed overflow output enabled by PIPE_SEG_ADDER_OVF_EN.
module pipe_seg_adder #(
  parameter int WIDTH  = 48,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int SEG = WIDTH / STAGES;

  logic             adv;
  logic [WIDTH-1:0] b_cond;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign b_cond   = sub ? ~b : b;

  // Stage k owns result bits [k*SEG +: SEG]; operand bits below that are already consumed
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int SW = WIDTH - k * SEG;
    localparam int LW = (k + 1) * SEG;

    logic [SW-1:0]  src_a;
    logic [SW-1:0]  src_b;
    logic           src_c;
    logic           src_v;
    logic [SEG:0]   seg_sum;
    logic [LW-1:0]  lo_d;
    logic [LW-1:0]  lo_q;
    logic           c_q;
    logic           v_q;

    if (k == 0) begin : g_in
      assign src_a = a;
      assign src_b = b_cond;
      assign src_c = sub | cin;
      assign src_v = in_valid && in_ready;
    end else begin : g_in
      assign src_a = g_stage[k-1].g_ops.a_q;
      assign src_b = g_stage[k-1].g_ops.b_q;
      assign src_c = g_stage[k-1].c_q;
      assign src_v = g_stage[k-1].v_q;
    end

    assign seg_sum = {1'b0, src_a[SEG-1:0]} + {1'b0, src_b[SEG-1:0]} + {{SEG{1'b0}}, src_c};

    if (k == 0) begin : g_lo
      assign lo_d = seg_sum[SEG-1:0];
    end else begin : g_lo
      assign lo_d = {seg_sum[SEG-1:0], g_stage[k-1].lo_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lo_q <= '0;
        c_q  <= 1'b0;
        v_q  <= 1'b0;
      end else if (adv) begin
        lo_q <= lo_d;
        c_q  <= seg_sum[SEG];
        v_q  <= src_v;
      end
    end

    if (k < STAGES - 1) begin : g_ops
      logic [SW-SEG-1:0] a_q;
      logic [SW-SEG-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= src_a[SW-1:SEG];
          b_q <= src_b[SW-1:SEG];
        end
      end
    end
  end

  assign sum       = g_stage[STAGES-1].lo_q;
  assign cout      = g_stage[STAGES-1].c_q;
  assign out_valid = g_stage[STAGES-1].v_q;

`ifdef PIPE_SEG_ADDER_OVF_EN
  logic ovf_q;
  logic a_msb;
  logic b_msb;
  logic s_msb;

  // The operand MSBs ride in the last stage's operand window, so no extra tracking is needed
  assign a_msb = g_stage[STAGES-1].src_a[SEG-1];
  assign b_msb = g_stage[STAGES-1].src_b[SEG-1];
  assign s_msb = g_stage[STAGES-1].seg_sum[SEG-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (adv) begin
      ovf_q <= (a_msb == b_msb) && (s_msb != a_msb);
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_seg_adder.sv
// tb/tb_pipe_seg_adder.sv - randomized scoreboard bench for pipe_seg_adder (WIDTH=48, STAGES=4)
module tb_pipe_seg_adder;
  localparam int W  = 48;
  localparam int ST = 4;
`ifdef PIPE_SEG_ADDER_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_out    = 0;
  res_t exp_q[$];

  pipe_seg_adder #(.WIDTH(W), .STAGES(ST)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Exact integer arithmetic: the answer a user would compute by hand
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c, input logic s);
    res_t        r;
    logic [W:0]  f;
    longint      sx;
    longint      sy;
    longint      ex;
    longint      smax;
    longint      smin;
    sx   = $signed(x);
    sy   = $signed(y);
    smax = (longint'(1) <<< (W - 1)) - 1;
    smin = -(longint'(1) <<< (W - 1));
    if (s) begin
      f      = {1'b0, x} - {1'b0, y};
      r.cout = (x >= y);
      ex     = sx - sy;
    end else begin
      f      = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
      r.cout = f[W];
      ex     = sx + sy + longint'(c);
    end
    r.sum = f[W-1:0];
    r.ovf = OVF_EN && ((ex > smax) || (ex < smin));
    return r;
  endfunction

  always @(negedge clk) begin
    res_t e;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid) check("in_ready_bp", in_ready, out_ready);
      else           check("in_ready_idle", in_ready, 1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("sb_sum", sum, e.sum);
          check("sb_cout", cout, e.cout);
          check("sb_ovf", ovf, e.ovf);
        end
        n_out++;
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
    end
  end

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input logic s);
    int   n = 0;
    logic acc;
    a = x; b = y; cin = c; sub = s; in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 1000);
    if (!acc) check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic expect_lat(input string tag, input logic [W-1:0] es, input logic ec, input logic eo);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    check({tag, "_lat"}, n, ST);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
    check({tag, "_ovf"}, ovf, eo);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int           base;
    bit           drv_done;
    logic [63:0]  r64;
    logic [3:0]   pat;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    send(48'hFFFF_FFFF_FFFF, 48'd1, 1'b0, 1'b0);
    expect_lat("ripple", 48'd0, 1'b1, 1'b0);
    send(48'd5, 48'd7, 1'b0, 1'b1);
    expect_lat("sub_neg", 48'hFFFF_FFFF_FFFE, 1'b0, 1'b0);
    send(48'd7, 48'd5, 1'b0, 1'b1);
    expect_lat("sub_pos", 48'd2, 1'b1, 1'b0);
    send(48'h7FFF_FFFF_FFFF, 48'd1, 1'b0, 1'b0);
    expect_lat("ovf", 48'h8000_0000_0000, 1'b0, OVF_EN);

    // Backpressure with out_ready cycling 1,0,0,1
    base = n_out;
    pat  = 4'b1001;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          logic [W-1:0] ai;
          ai = W'(i);
          send(ai, ai * 48'h100, ai[0], 1'b0);
        end
      end
      begin
        int cyc = 0;
        while (n_out < base + 8 && cyc < 300) begin
          out_ready = pat[cyc % 4];
          @(posedge clk); #1;
          cyc++;
        end
        out_ready = 1'b1;
      end
    join
    check("bp_count", n_out - base, 8);

    // Reset with work in flight and a result waiting at the output
    for (int i = 0; i < 5; i++) send(48'd100 + W'(i), 48'd3, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_sum", sum, 0);
    check("midrst_cout", cout, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < ST + 2; i++) begin
      @(negedge clk);
      check("post_rst_no_stale", out_valid, 0);
    end
    @(posedge clk); #1;

    // Random traffic with random backpressure and idle gaps
    drv_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          logic [W-1:0] x;
          logic [W-1:0] y;
          int           sel;
          r64 = {$urandom(), $urandom()}; x = r64[W-1:0];
          r64 = {$urandom(), $urandom()}; y = r64[W-1:0];
          sel = $urandom_range(0, 7);
          if (sel == 0) x = '1;
          if (sel == 1) y = x;
          if (sel == 2) y = '0;
          if ($urandom_range(0, 4) == 0) begin
            @(posedge clk); #1;
          end
          send(x, y, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        drv_done = 1'b1;
      end
      begin
        int cyc = 0;
        while (!(drv_done && exp_q.size() == 0) && cyc < 5000) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
          cyc++;
        end
        out_ready = 1'b1;
      end
    join
    check("drain_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
